// File: rtl/register_file_16x16.sv
// 16 x 16-bit general-purpose register file: two combinational read ports (Rs, Rt)
// and one synchronous write port (Rd). Synchronous active-low reset clears every register.
module register_file_16x16 (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  Rs,
  input  logic [3:0]  Rt,
  input  logic [3:0]  Rd,
  input  logic [15:0] RW,
  input  logic        wr,
  output logic [15:0] Rout1,
  output logic [15:0] Rout2
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned NREGS  = 16;

  logic [DATA_W-1:0] r_regs [NREGS];
  logic [NREGS-1:0]  w_wr_sel;
  logic [ADDR_W-1:0] w_rd_addr;

  assign w_rd_addr = Rd;

  // One-hot write select; all zeros when the write port is idle.
  always_comb begin
    w_wr_sel = '0;
    if (wr) begin
      w_wr_sel[w_rd_addr] = 1'b1;
    end
  end

  // Reset takes priority over a write presented on the same edge.
  for (genvar g = 0; g < NREGS; g++) begin : g_reg
    always_ff @(posedge clk) begin
      if (!rst) begin
        r_regs[g] <= '0;
      end else if (w_wr_sel[g]) begin
        r_regs[g] <= RW;
      end
    end
  end

  // No write-to-read bypass: reads show the stored value until the capturing edge.
  assign Rout1 = r_regs[Rs];
  assign Rout2 = r_regs[Rt];

endmodule

// File: tb/tb_register_file_16x16.sv
// Directed self-checking bench for register_file_16x16.
module tb_register_file_16x16;

  logic        clk;
  logic        rst;
  logic [3:0]  Rs;
  logic [3:0]  Rt;
  logic [3:0]  Rd;
  logic [15:0] RW;
  logic        wr;
  logic [15:0] Rout1;
  logic [15:0] Rout2;

  int checks;
  int failures;

  register_file_16x16 dut (
    .clk   (clk),
    .rst   (rst),
    .Rs    (Rs),
    .Rt    (Rt),
    .Rd    (Rd),
    .RW    (RW),
    .wr    (wr),
    .Rout1 (Rout1),
    .Rout2 (Rout2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; wr = 1'b0; Rd = 4'd0; RW = 16'h0; Rs = 4'd0; Rt = 4'd0;
    tick();
    rst = 1'b1;
    tick();
    for (int a = 0; a < 16; a++) begin
      Rs = a[3:0];
      Rt = 4'(15 - a);
      #1;
      checks++;
      if (Rout1 !== 16'h0000) begin
        failures++;
        $display("FAIL reset_rout1 addr=%0d got=%h exp=0000", a, Rout1);
      end
      checks++;
      if (Rout2 !== 16'h0000) begin
        failures++;
        $display("FAIL reset_rout2 addr=%0d got=%h exp=0000", 15 - a, Rout2);
      end
    end
  endtask

  task automatic test_basic_write;
    Rd = 4'd15; RW = 16'h0450; wr = 1'b1;
    tick();
    wr = 1'b0;
    Rs = 4'd8; Rt = 4'd15;
    #1;
    checks++;
    if (Rout1 !== 16'h0000) begin
      failures++;
      $display("FAIL basic_r8 got=%h exp=0000", Rout1);
    end
    checks++;
    if (Rout2 !== 16'h0450) begin
      failures++;
      $display("FAIL basic_r15 got=%h exp=0450", Rout2);
    end
  endtask

  task automatic test_write_disabled;
    Rd = 4'd15; RW = 16'hFFFF; wr = 1'b0;
    repeat (3) tick();
    Rt = 4'd15;
    #1;
    checks++;
    if (Rout2 !== 16'h0450) begin
      failures++;
      $display("FAIL wr_disabled_r15 got=%h exp=0450", Rout2);
    end
  endtask

  task automatic test_r0_dual_read;
    Rd = 4'd0; RW = 16'h1254; wr = 1'b1;
    tick();
    wr = 1'b0;
    Rs = 4'd0; Rt = 4'd0;
    #1;
    checks++;
    if (Rout1 !== 16'h1254) begin
      failures++;
      $display("FAIL r0_rout1 got=%h exp=1254", Rout1);
    end
    checks++;
    if (Rout2 !== 16'h1254) begin
      failures++;
      $display("FAIL r0_rout2 got=%h exp=1254", Rout2);
    end
  endtask

  task automatic test_same_reg;
    Rs = 4'd9; Rd = 4'd9; RW = 16'h3347; wr = 1'b1;
    #1;
    checks++;
    if (Rout1 !== 16'h0000) begin
      failures++;
      $display("FAIL same_reg_before got=%h exp=0000", Rout1);
    end
    tick();
    wr = 1'b0;
    #1;
    checks++;
    if (Rout1 !== 16'h3347) begin
      failures++;
      $display("FAIL same_reg_after got=%h exp=3347", Rout1);
    end
    Rt = 4'd15;
    #1;
    checks++;
    if (Rout2 !== 16'h0450) begin
      failures++;
      $display("FAIL same_reg_r15 got=%h exp=0450", Rout2);
    end
  endtask

  task automatic test_back_to_back;
    Rd = 4'd5; RW = 16'h1111; wr = 1'b1;
    tick();
    RW = 16'h2222;
    tick();
    wr = 1'b0;
    Rs = 4'd5; Rt = 4'd4;
    #1;
    checks++;
    if (Rout1 !== 16'h2222) begin
      failures++;
      $display("FAIL b2b_r5 got=%h exp=2222", Rout1);
    end
    checks++;
    if (Rout2 !== 16'h0000) begin
      failures++;
      $display("FAIL b2b_r4 got=%h exp=0000", Rout2);
    end
  endtask

  task automatic test_between_edges;
    // Enable pulses high between edges but is low at the edge: no write.
    Rd = 4'd6; RW = 16'hAAAA; wr = 1'b1;
    #2;
    wr = 1'b0; Rd = 4'd7; RW = 16'h5555;
    tick();
    Rs = 4'd6; Rt = 4'd7;
    #1;
    checks++;
    if (Rout1 !== 16'h0000) begin
      failures++;
      $display("FAIL between_r6 got=%h exp=0000", Rout1);
    end
    checks++;
    if (Rout2 !== 16'h0000) begin
      failures++;
      $display("FAIL between_r7 got=%h exp=0000", Rout2);
    end
  endtask

  task automatic test_reset_vs_write;
    rst = 1'b0; wr = 1'b1; Rd = 4'd3; RW = 16'hABCD;
    tick();
    rst = 1'b1; wr = 1'b0;
    for (int a = 0; a < 16; a++) begin
      Rs = a[3:0];
      Rt = a[3:0];
      #1;
      checks++;
      if (Rout1 !== 16'h0000) begin
        failures++;
        $display("FAIL rst_vs_wr_rout1 addr=%0d got=%h exp=0000", a, Rout1);
      end
      checks++;
      if (Rout2 !== 16'h0000) begin
        failures++;
        $display("FAIL rst_vs_wr_rout2 addr=%0d got=%h exp=0000", a, Rout2);
      end
    end
  endtask

  task automatic test_resume_after_reset;
    Rd = 4'd3; RW = 16'hBEEF; wr = 1'b1;
    tick();
    wr = 1'b0;
    Rs = 4'd3; Rt = 4'd2;
    #1;
    checks++;
    if (Rout1 !== 16'hBEEF) begin
      failures++;
      $display("FAIL resume_r3 got=%h exp=beef", Rout1);
    end
    checks++;
    if (Rout2 !== 16'h0000) begin
      failures++;
      $display("FAIL resume_r2 got=%h exp=0000", Rout2);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst = 1'b0; wr = 1'b0; Rs = 4'd0; Rt = 4'd0; Rd = 4'd0; RW = 16'h0;
    test_reset();
    test_basic_write();
    test_write_disabled();
    test_r0_dual_read();
    test_same_reg();
    test_back_to_back();
    test_between_edges();
    test_reset_vs_write();
    test_resume_after_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
